// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter feeding two requesters into one shared 4x4 multiplier core
module mult_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       mul_start,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic       mul_done,
    input  logic [7:0] mul_p,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_id,
    output logic [7:0] res_p,
    output logic       res_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0] state;
    logic       last_grant;
    logic [7:0] timer;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       id_q;
    logic [7:0] p_q;
    logic       err_q;
    logic       grant;
    logic       accept;
    logic       timeout_hit;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready  = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready  = rst_n && (state == IDLE) && req1_valid && grant;
    assign accept      = req0_ready || req1_ready;
    // Timer counts completed WAIT cycles; the last allowed one ends the wait.
    assign timeout_hit = (timer == 8'(TIMEOUT - 1));

    assign mul_start = (state == ISSUE);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign res_valid = (state == RESP);
    assign res_id    = id_q;
    assign res_p     = p_q;
    assign res_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            timer      <= 8'd0;
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            id_q       <= 1'b0;
            p_q        <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= grant ? req1_a : req0_a;
                        b_q   <= grant ? req1_b : req0_b;
                        id_q  <= grant;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 8'd1;
                    if (mul_done) begin
                        p_q   <= mul_p;
                        err_q <= 1'b0;
                        state <= RESP;
                    end else if (timeout_hit) begin
                        p_q   <= 8'd0;
                        err_q <= 1'b1;
                        state <= RESP;
                    end
                end
                default: begin
                    if (res_ready) begin
                        last_grant <= id_q;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - scoreboard and vector table bench for mult_arbiter
module tb_mult_arbiter;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_a = 4'd0;
    logic [3:0] req0_b = 4'd0;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_a = 4'd0;
    logic [3:0] req1_b = 4'd0;
    logic       req1_ready;
    logic       mul_start;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic       mul_done = 1'b0;
    logic [7:0] mul_p = 8'd0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic       res_id;
    logic [7:0] res_p;
    logic       res_err;

    mult_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_p(res_p), .res_err(res_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [7:0] p;
        bit         err;
        int         lat;
    } exp_t;

    typedef struct {
        bit         id;
        logic [3:0] a;
        logic [3:0] b;
        int         k;
        int         force_p;
        int         hold;
        logic [7:0] p;
        bit         err;
    } vec_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [7:0] last_p = 8'd0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Caller has set the valids at a negedge with the DUT in IDLE.
    task automatic run_op(input bit id, input int k, input int force_p, input int hold, input bit keep);
        exp_t e;
        int lat;
        int starts;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] hp;
        bit timed;
        a = id ? req1_a : req0_a;
        b = id ? req1_b : req0_b;
        timed = (k == 0) || (k > TO);
        e.id  = id;
        e.err = timed;
        e.p   = timed ? 8'd0 : (force_p >= 0 ? 8'(force_p) : 8'(a) * 8'(b));
        e.lat = timed ? TO + 1 : k + 1;
        sb.push_back(e);
        #1;
        chk("ready_grant", id ? req1_ready : req0_ready, 1);
        chk("ready_other", id ? req0_ready : req1_ready, 0);
        @(negedge clk);
        if (!keep) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        chk("start_issue", mul_start, 1);
        chk("mul_a", mul_a, a);
        chk("mul_b", mul_b, b);
        starts = 0;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            mul_done = 1'b0;
            if (res_valid) break;
            starts += mul_start;
            if (lat == k) begin
                mul_done = 1'b1;
                mul_p = force_p >= 0 ? 8'(force_p) : 8'(mul_a) * 8'(mul_b);
            end
        end
        chk("res_valid", res_valid, 1);
        chk("latency", lat, e.lat);
        chk("extra_start", starts, 0);
        if (hold > 0) begin
            hp = res_p;
            if (id) req0_valid = 1'b1; else req1_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                #1;
                chk("hold_valid", res_valid, 1);
                chk("hold_p", res_p, hp);
                chk("hold_ready", {req0_ready, req1_ready}, 0);
                chk("hold_start", mul_start, 0);
                @(negedge clk);
            end
            if (!keep) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        e = sb.pop_front();
        chk("res_id", res_id, e.id);
        chk("res_p", res_p, e.p);
        chk("res_err", res_err, e.err);
        last_p = e.p;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{id: 1'b0, a: 4'd3,  b: 4'd5,  k: 10, force_p: -1, hold: 0, p: 8'd15,  err: 1'b0};
        vecs[1] = '{id: 1'b1, a: 4'd15, b: 4'd15, k: 1,  force_p: -1, hold: 0, p: 8'd225, err: 1'b0};
        vecs[2] = '{id: 1'b0, a: 4'd0,  b: 4'd9,  k: 3,  force_p: -1, hold: 0, p: 8'd0,   err: 1'b0};
        vecs[3] = '{id: 1'b1, a: 4'd4,  b: 4'd4,  k: 0,  force_p: -1, hold: 0, p: 8'd0,   err: 1'b1};
        vecs[4] = '{id: 1'b0, a: 4'd7,  b: 4'd9,  k: 15, force_p: 42, hold: 0, p: 8'd42,  err: 1'b0};
        vecs[5] = '{id: 1'b0, a: 4'd15, b: 4'd1,  k: 2,  force_p: -1, hold: 5, p: 8'd15,  err: 1'b0};

        req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {mul_start, mul_a, mul_b, res_valid, res_id, res_p, res_err, req0_ready, req1_ready}, 0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            if (vecs[i].id) begin
                req1_a = vecs[i].a; req1_b = vecs[i].b; req1_valid = 1'b1;
            end else begin
                req0_a = vecs[i].a; req0_b = vecs[i].b; req0_valid = 1'b1;
            end
            run_op(vecs[i].id, vecs[i].k, vecs[i].force_p, vecs[i].hold, 1'b0);
            chk("table_p", last_p, vecs[i].p);
            chk("table_err", res_err, vecs[i].err);
        end

        // A completion pulse while idle must not produce a result.
        mul_done = 1'b1; mul_p = 8'd99;
        @(negedge clk);
        mul_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_done_valid", res_valid, 0);
        chk("idle_done_p", res_p, last_p);
        chk("idle_done_start", mul_start, 0);

        // Reset in the middle of WAIT, then a stale completion.
        req0_a = 4'd5; req0_b = 4'd5; req0_valid = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        chk("midreset_outputs", {mul_start, mul_a, mul_b, res_valid, res_id, res_p, res_err, req0_ready, req1_ready}, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        mul_done = 1'b1; mul_p = 8'd77;
        @(negedge clk);
        mul_done = 1'b0;
        begin
            int seen;
            seen = 0;
            repeat (5) begin
                @(negedge clk);
                seen += res_valid + mul_start;
            end
            chk("midreset_quiet", seen, 0);
            chk("midreset_p", res_p, 0);
        end

        // Both valid continuously: alternate starting with req0.
        req0_a = 4'd7;  req0_b = 4'd9;
        req1_a = 4'd15; req1_b = 4'd15;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            run_op(r[0], 4, -1, 0, 1'b1);
            chk("rr_p", last_p, r[0] ? 225 : 63);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles in WAIT for mul_done before abort (1..255).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 req0_valid / req1_valid  in  1 each  requester operand pair valid.
REQ-005 req0_a, req0_b / req1_a, req1_b  in  4 each  unsigned operands.
REQ-006 req0_ready / req1_ready  out  1 each  request accepted this cycle.
REQ-007 mul_start  out  1  one-cycle start pulse to shared multiplier core.
REQ-008 mul_a, mul_b  out  4 each  operands to core, stable from ISSUE through end of WAIT.
REQ-009 mul_done  in  1  core completion pulse.
REQ-010 mul_p  in  8  core product, valid when mul_done=1.
REQ-011 res_valid  out  1  result available.
REQ-012 res_ready  in  1  result consumer accepts.
REQ-013 res_id  out  1  requester that owns the result.
REQ-014 res_p  out  8  product.
REQ-015 res_err  out  1  result produced by timeout, not by core.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; encoding is free.
REQ-017 IDLE: grant = sole valid requester; if both valid, grant the one not equal to last_grant (round-robin).
REQ-018 reqN_ready SHALL be combinational: 1 only in IDLE and only for the granted requester with valid=1.
REQ-019 On valid&ready: latch a, b, id into internal registers; next state ISSUE.
REQ-020 Non-granted requester SHALL see ready=0; its valid and operands must stay held and are never dropped.
REQ-021 ISSUE: mul_start=1 for exactly one cycle; timer cleared to 0; next state WAIT.
REQ-022 mul_start SHALL be 0 in every state other than ISSUE.
REQ-023 WAIT: timer increments each cycle; mul_done=1 -> capture mul_p into res_p, res_err=0, next RESP.
REQ-024 WAIT: timer reaching TIMEOUT with mul_done=0 -> res_p=0, res_err=1, next RESP.
REQ-025 mul_done and timeout in the same cycle: mul_done wins (res_err=0, real product).
REQ-026 mul_done outside WAIT SHALL be ignored; no state or output change.
REQ-027 RESP: res_valid=1; res_id/res_p/res_err held constant until res_ready=1.
REQ-028 RESP with res_ready=1: last_grant <= res_id; res_valid falls next cycle; next IDLE.
REQ-029 No new request accepted while not in IDLE (one outstanding operation).
REQ-030 Latency: accept at cycle N, mul_start at N+1, res_valid the cycle after mul_done.
REQ-031 Product width 8 bits; no truncation or sign handling (4x4 unsigned max 225).

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, last_grant=1 (req0 wins first tie), timer=0.
REQ-033 During reset: mul_start=0, mul_a=mul_b=0, res_valid=0, res_id=0, res_p=0, res_err=0, both ready=0.
REQ-034 Reset mid-operation (ISSUE/WAIT/RESP) SHALL abandon the operation; a later mul_done is ignored.
REQ-035 First edge after rst_n deasserts SHALL evaluate IDLE normally.

Verification
REQ-036 req0 a=3 b=5, core done after 10 cycles p=15 -> one mul_start, res_valid id=0 p=15 err=0.
REQ-037 Both valid continuously (req0 7x9, req1 15x15) -> served order 0,1,0,1; products 63, 225 alternate.
REQ-038 Core never asserts done, TIMEOUT=15 -> res_valid 16 cycles after ISSUE, err=1, p=0.
REQ-039 res_ready held 0 for 5 cycles in RESP -> outputs stable, req ready stays 0, no mul_start.
REQ-040 mul_done=1 p=42 on exact timeout cycle -> err=0 p=42; mul_done pulse in IDLE -> no effect.
REQ-041 rst_n low during WAIT, late mul_done after release -> IDLE, all outputs 0, no res_valid.
